cnn_train_core: RTL and testbench

- Single-neuron-layer CNN training engine: one 3x3 input patch (9 samples) is convolved with 10 independent 3x3 kernels, producing 10 class scores.
- On each Start, runs one training iteration: feed-forward (FF), error back-propagation (FB) and gradient weight update (GR).
- Fixed-point signed Q(WL-FL).FL throughout.
- Sits under the testbench/top as the whole compute datapath; weights are internal registers.

---
 rtl/cnn_train_core.sv | 196 +++++++++++++++++++
 tb/tb_cnn_train_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_train_core.sv
// rtl/cnn_train_core.sv - 3x3 patch, 10-kernel CNN training engine (FF, FB, GR per Start)
// Optional CNN_RELU_EN: ReLU activation in FF and ReLU derivative masking in FB.
module cnn_train_core #(
  parameter int              KERNEL_SIZE   = 3,
  parameter int              WL            = 16,
  parameter int              FL            = 14,
  parameter logic [WL-1:0]   LEARNING_RATE = 16'd15552
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Start,
  output logic          Done,
  input  logic [WL-1:0] in1,
  input  logic [WL-1:0] in2,
  input  logic [WL-1:0] in3,
  input  logic [WL-1:0] in4,
  input  logic [WL-1:0] in5,
  input  logic [WL-1:0] in6,
  input  logic [WL-1:0] in7,
  input  logic [WL-1:0] in8,
  input  logic [WL-1:0] in9,
  input  logic [WL-1:0] label1,
  input  logic [WL-1:0] label2,
  input  logic [WL-1:0] label3,
  input  logic [WL-1:0] label4,
  input  logic [WL-1:0] label5,
  input  logic [WL-1:0] label6,
  input  logic [WL-1:0] label7,
  input  logic [WL-1:0] label8,
  input  logic [WL-1:0] label9,
  input  logic [WL-1:0] label10,
  output logic [WL-1:0] out1,
  output logic [WL-1:0] out2,
  output logic [WL-1:0] out3,
  output logic [WL-1:0] out4,
  output logic [WL-1:0] out5,
  output logic [WL-1:0] out6,
  output logic [WL-1:0] out7,
  output logic [WL-1:0] out8,
  output logic [WL-1:0] out9,
  output logic [WL-1:0] out10
);

  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NK   = 10;
  localparam int PW   = 2 * WL;
  localparam int AW   = 2 * WL + 4;
  localparam int XW   = 3 * WL;

  localparam logic signed [XW-1:0] SMAX   = XW'(2 ** (WL - 1) - 1);
  localparam logic signed [XW-1:0] SMIN   = ~SMAX;
  localparam logic signed [WL-1:0] W_INIT = WL'(1 << (FL - 3));

  typedef enum logic [2:0] {S_IDLE, S_FF, S_FB, S_GR, S_DONE} state_t;

  state_t state_q, state_d;

  logic signed [WL-1:0] x_q   [0:TAPS-1];
  logic signed [WL-1:0] lab_q [0:NK-1];
  logic signed [WL-1:0] w_q   [0:NK-1][0:TAPS-1];
  logic signed [WL-1:0] out_q [0:NK-1];
  logic signed [WL-1:0] e_q   [0:NK-1];
  logic signed [AW-1:0] acc_q;
  logic [3:0]           k_q, j_q;

  logic last_j, last_k;
  logic done;

  // Every narrowing in the datapath goes through this clamp, so nothing wraps.
  function automatic logic signed [WL-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SMAX)      sat = SMAX[WL-1:0];
    else if (v < SMIN) sat = SMIN[WL-1:0];
    else               sat = v[WL-1:0];
  endfunction

  assign last_j = (j_q == 4'(TAPS - 1));
  assign last_k = (k_q == 4'(NK - 1));

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (Start) state_d = S_FF;
      S_FF:   if (last_j && last_k) state_d = S_FB;
      S_FB:   if (last_k) state_d = S_GR;
      S_GR:   if (last_j && last_k) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Done = done;

  logic signed [WL-1:0] wsel, xsel, ff_val, fb_val, wnew;
  logic signed [PW-1:0] prod, eprod;
  logic signed [AW-1:0] acc_sum;
  logic signed [XW-1:0] diff, g, dprod, d;

  always_comb begin
    wsel    = w_q[k_q][j_q];
    xsel    = x_q[j_q];
    prod    = PW'(wsel) * PW'(xsel);
    acc_sum = acc_q + AW'(prod);
    ff_val  = sat(XW'(acc_sum >>> FL));
`ifdef CNN_RELU_EN
    if (ff_val[WL-1]) ff_val = '0;
`endif
    diff    = XW'(out_q[k_q]) - XW'(lab_q[k_q]);
    fb_val  = sat(diff);
`ifdef CNN_RELU_EN
    if (out_q[k_q] == '0) fb_val = '0;
`endif
    eprod   = PW'(e_q[k_q]) * PW'(xsel);
    g       = XW'(eprod >>> FL);
    dprod   = XW'($signed({1'b0, LEARNING_RATE})) * g;
    d       = dprod >>> FL;
    wnew    = sat(XW'(wsel) - d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < NK; k++) begin
        out_q[k] <= '0;
        e_q[k]   <= '0;
        lab_q[k] <= '0;
        for (int j = 0; j < TAPS; j++) w_q[k][j] <= W_INIT;
      end
      for (int j = 0; j < TAPS; j++) x_q[j] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          k_q   <= '0;
          j_q   <= '0;
          acc_q <= '0;
          if (Start) begin
            x_q[0] <= in1;  x_q[1] <= in2;  x_q[2] <= in3;
            x_q[3] <= in4;  x_q[4] <= in5;  x_q[5] <= in6;
            x_q[6] <= in7;  x_q[7] <= in8;  x_q[8] <= in9;
            lab_q[0] <= label1;  lab_q[1] <= label2;  lab_q[2] <= label3;
            lab_q[3] <= label4;  lab_q[4] <= label5;  lab_q[5] <= label6;
            lab_q[6] <= label7;  lab_q[7] <= label8;  lab_q[8] <= label9;
            lab_q[9] <= label10;
          end
        end
        S_FF: begin
          if (last_j) begin
            out_q[k_q] <= ff_val;
            acc_q      <= '0;
            j_q        <= '0;
            k_q        <= last_k ? 4'd0 : k_q + 4'd1;
          end else begin
            acc_q <= acc_sum;
            j_q   <= j_q + 4'd1;
          end
        end
        S_FB: begin
          e_q[k_q] <= fb_val;
          k_q      <= last_k ? 4'd0 : k_q + 4'd1;
        end
        S_GR: begin
          w_q[k_q][j_q] <= wnew;
          if (last_j) begin
            j_q <= '0;
            k_q <= last_k ? 4'd0 : k_q + 4'd1;
          end else begin
            j_q <= j_q + 4'd1;
          end
        end
        default: begin
          k_q <= '0;
          j_q <= '0;
        end
      endcase
    end
  end

  assign out1  = out_q[0];
  assign out2  = out_q[1];
  assign out3  = out_q[2];
  assign out4  = out_q[3];
  assign out5  = out_q[4];
  assign out6  = out_q[5];
  assign out7  = out_q[6];
  assign out8  = out_q[7];
  assign out9  = out_q[8];
  assign out10 = out_q[9];

endmodule

// File: tb/tb_cnn_train_core.sv
// tb/tb_cnn_train_core.sv - randomized self-checking bench for cnn_train_core
module tb_cnn_train_core;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic        Done;
  logic [15:0] xin [9];
  logic [15:0] lin [10];
  logic [15:0] oo  [10];

  int total = 0;
  int bad   = 0;

  longint wm [10][9];
  longint om [10];
  longint xm [9];
  longint lm [10];

  always #5 CLK = ~CLK;

  cnn_train_core dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Done(Done),
    .in1(xin[0]), .in2(xin[1]), .in3(xin[2]), .in4(xin[3]), .in5(xin[4]),
    .in6(xin[5]), .in7(xin[6]), .in8(xin[7]), .in9(xin[8]),
    .label1(lin[0]), .label2(lin[1]), .label3(lin[2]), .label4(lin[3]),
    .label5(lin[4]), .label6(lin[5]), .label7(lin[6]), .label8(lin[7]),
    .label9(lin[8]), .label10(lin[9]),
    .out1(oo[0]), .out2(oo[1]), .out3(oo[2]), .out4(oo[3]), .out5(oo[4]),
    .out6(oo[5]), .out7(oo[6]), .out8(oo[7]), .out9(oo[8]), .out10(oo[9])
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint msat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 10; k++) begin
      om[k] = 0;
      for (int j = 0; j < 9; j++) wm[k][j] = 2048;
    end
  endtask

  // One training iteration computed directly from the arithmetic rules.
  task automatic model_iter();
    longint acc, e, g, dd;
    longint ev [10];
    for (int k = 0; k < 10; k++) begin
      acc = 0;
      for (int j = 0; j < 9; j++) acc += wm[k][j] * xm[j];
      om[k] = msat(acc >>> 14);
`ifdef CNN_RELU_EN
      if (om[k] < 0) om[k] = 0;
`endif
    end
    for (int k = 0; k < 10; k++) begin
      e = msat(om[k] - lm[k]);
`ifdef CNN_RELU_EN
      if (om[k] == 0) e = 0;
`endif
      ev[k] = e;
    end
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 9; j++) begin
        g  = (ev[k] * xm[j]) >>> 14;
        dd = (15552 * g) >>> 14;
        wm[k][j] = msat(wm[k][j] - dd);
      end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 9; i++)  xin[i] = xm[i][15:0];
    for (int i = 0; i < 10; i++) lin[i] = lm[i][15:0];
  endtask

  task automatic cmp_all(input string tag);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_out%0d", tag, k + 1), longint'($signed(oo[k])), om[k]);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 9; j++)
        check($sformatf("%s_w%0d_%0d", tag, k + 1, j + 1),
              longint'($signed(dut.w_q[k][j])), wm[k][j]);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  // Counts cycles after the sampling edge until Done is seen.
  task automatic wait_done(input string tag, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int c = 1; c <= 400 && !found; c++) begin
      @(negedge CLK);
      if (Done) begin
        n = c;
        found = 1'b1;
      end
    end
    check({tag, "_done_seen"}, longint'(found), 1);
  endtask

  task automatic run_iter(input string tag);
    int n;
    @(negedge CLK);
    apply_inputs();
    Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_done(tag, n);
    check({tag, "_latency"}, n, 191);
    model_iter();
    cmp_all(tag);
    @(negedge CLK);
    check({tag, "_done_pulse"}, longint'(Done), 0);
  endtask

  initial begin
    int n, cnt;
    RESET = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 9; i++)  xin[i] = '0;
    for (int i = 0; i < 10; i++) lin[i] = '0;

    do_reset();
    cmp_all("rst");
    check("rst_done", longint'(Done), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Done) cnt++;
    end
    check("idle_no_done", cnt, 0);

    // Start held high: two back-to-back iterations.
    for (int i = 0; i < 9; i++)  xm[i] = 4096;
    for (int i = 0; i < 10; i++) lm[i] = 4096;
    @(negedge CLK);
    apply_inputs();
    Start = 1'b1;
    @(posedge CLK);
    wait_done("it1", n);
    check("it1_latency", n, 191);
    model_iter();
    cmp_all("it1");
    check("it1_out_const", longint'($signed(oo[0])), 4608);
    check("it1_w_const", longint'($signed(dut.w_q[9][8])), 1927);
    repeat (5) @(negedge CLK);
    Start = 1'b0;
    wait_done("it2", n);
    check("it2_spacing", n + 5, 192);
    model_iter();
    cmp_all("it2");
    check("it2_out_const", longint'($signed(oo[4])), 4335);
    cnt = 0;
    repeat (30) begin
      @(negedge CLK);
      if (Done) cnt++;
    end
    check("it2_stops", cnt, 0);

    // Random patches and labels.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 9; i++)  xm[i] = longint'($urandom_range(16383)) - 8192;
      for (int i = 0; i < 10; i++) lm[i] = longint'($urandom_range(32767)) - 16384;
      run_iter($sformatf("rnd%0d", r));
    end

    // Saturation of outputs and weight updates.
    do_reset();
    for (int i = 0; i < 9; i++)  xm[i] = 32767;
    for (int i = 0; i < 10; i++) lm[i] = -32768;
    run_iter("sat0");
    check("sat0_out_clamp", longint'($signed(oo[2])), 32767);
    for (int r = 1; r < 4; r++) run_iter($sformatf("sat%0d", r));

    // Reset in the middle of GR.
    do_reset();
    for (int i = 0; i < 9; i++)  xm[i] = 4096;
    for (int i = 0; i < 10; i++) lm[i] = 4096;
    @(negedge CLK);
    apply_inputs();
    Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (150) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    model_reset();
    cmp_all("midrst");
    check("midrst_done", longint'(Done), 0);
    RESET = 1'b0;
    run_iter("after_rst");
    check("after_rst_out_const", longint'($signed(oo[9])), 4608);

    // Negative patch: exercises the optional ReLU path.
    do_reset();
    for (int i = 0; i < 9; i++)  xm[i] = -4096;
    for (int i = 0; i < 10; i++) lm[i] = 0;
    run_iter("neg");
`ifdef CNN_RELU_EN
    check("neg_out_const", longint'($signed(oo[0])), 0);
    check("neg_w_const", longint'($signed(dut.w_q[0][0])), 2048);
`else
    check("neg_out_const", longint'($signed(oo[0])), -4608);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
